// File: rtl/lcd_8080_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_8080_rx
// Purpose  : Target-side receiver for the 8080-style parallel LCD bus that the
//            CPU bit-bangs through the AHB LCD GPIO peripheral. The
//            asynchronous bus pins are synchronised into HCLK. WR rising edges
//            are decoded into command/data words and buffered in a
//            first-word-fall-through FIFO. RD cycles are answered with an ID
//            or a status word.
// Option   : define LCD_8080_RX_PIXCNT_EN to build the pixel counter
//            (pix_count). When it is undefined, pix_count is tied to zero.
// Ports    : HCLK, HRESETn        - clock, asynchronous active-low reset
//            LCD_CS/RS/WR/RD/RST  - 8080 bus control pins (asynchronous)
//            LCD_DATA_IN          - 16-bit bus data from the initiator
//            LCD_DATA_OUT/_OE     - read-back data and its drive enable
//            out_valid/out_ready  - FIFO head handshake
//            out_is_data/out_word - FIFO head (RS bit, data word)
//            fifo_level           - number of words held
//            overflow/ovf_clr     - sticky drop flag and its clear pulse
//            lcd_reset_active     - synchronised LCD_RST is asserted
//            pix_count            - pixel counter (optional)
// Revision : 1.0 - initial release
// ============================================================================
module lcd_8080_rx #(
  parameter int          DEPTH   = 8,
  parameter int          LVLW    = 4,
  parameter logic [15:0] ID_CODE = 16'h9341,
  parameter int          PIXW    = 20
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            LCD_CS,
  input  logic            LCD_RS,
  input  logic            LCD_WR,
  input  logic            LCD_RD,
  input  logic            LCD_RST,
  input  logic [15:0]     LCD_DATA_IN,
  output logic [15:0]     LCD_DATA_OUT,
  output logic            LCD_DATA_OE,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_is_data,
  output logic [15:0]     out_word,
  output logic [LVLW-1:0] fifo_level,
  output logic            overflow,
  input  logic            ovf_clr,
  output logic            lcd_reset_active,
  output logic [PIXW-1:0] pix_count
);

  localparam int              c_AW     = $clog2(DEPTH);
  localparam logic [LVLW-1:0] c_FULL   = LVLW'(DEPTH);
  localparam logic [7:0]      c_CMD_ID = 8'h04;

  // --------------------------------------------------------------------------
  // Pin synchronisers. Reset values correspond to an idle bus so that
  // leaving reset never looks like a strobe edge.
  // --------------------------------------------------------------------------
  logic        r_cs_s1, r_cs_s2;
  logic        r_rs_s1, r_rs_s2;
  logic        r_wr_s1, r_wr_s2, r_wr_d;
  logic        r_rd_s1, r_rd_s2;
  logic        r_rst_s1, r_rst_s2;
  logic [15:0] r_data_s1, r_data_s2;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_rs_s1   <= 1'b0;
      r_rs_s2   <= 1'b0;
      r_wr_s1   <= 1'b1;
      r_wr_s2   <= 1'b1;
      r_wr_d    <= 1'b1;
      r_rd_s1   <= 1'b1;
      r_rd_s2   <= 1'b1;
      r_rst_s1  <= 1'b1;
      r_rst_s2  <= 1'b1;
      r_data_s1 <= 16'h0000;
      r_data_s2 <= 16'h0000;
    end else begin
      r_cs_s1   <= LCD_CS;
      r_cs_s2   <= r_cs_s1;
      r_rs_s1   <= LCD_RS;
      r_rs_s2   <= r_rs_s1;
      r_wr_s1   <= LCD_WR;
      r_wr_s2   <= r_wr_s1;
      r_wr_d    <= r_wr_s2;
      r_rd_s1   <= LCD_RD;
      r_rd_s2   <= r_rd_s1;
      r_rst_s1  <= LCD_RST;
      r_rst_s2  <= r_rst_s1;
      r_data_s1 <= LCD_DATA_IN;
      r_data_s2 <= r_data_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Write decode. The rising WR edge is registered into a one-entry push
  // stage. The FIFO consumes it on the following edge, so a word on an empty
  // FIFO becomes visible three edges after WR is first sampled high.
  // --------------------------------------------------------------------------
  logic        w_wr_rise;
  logic        r_push_vld;
  logic        r_push_rs;
  logic [15:0] r_push_data;

  assign w_wr_rise = r_wr_s2 & ~r_wr_d & ~r_cs_s2;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_push_vld  <= 1'b0;
      r_push_rs   <= 1'b0;
      r_push_data <= 16'h0000;
    end else begin
      r_push_vld  <= w_wr_rise;
      r_push_rs   <= r_rs_s2;
      r_push_data <= r_data_s2;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control. Panel reset overrides everything: a pending push is
  // discarded and the queue is emptied on every cycle it is held.
  // --------------------------------------------------------------------------
  logic            w_panel_rst;
  logic            w_full;
  logic            w_valid;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_drop;
  logic [16:0]     w_head;
  logic [LVLW-1:0] w_level;

  logic [16:0]     r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [LVLW-1:0] r_count;

  assign w_panel_rst = ~r_rst_s2;
  assign w_full      = (r_count == c_FULL);
  assign w_valid     = (r_count != '0) & ~w_panel_rst;
  assign w_pop       = w_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok   = r_push_vld & ~w_panel_rst & (~w_full | w_pop);
  assign w_drop      = r_push_vld & ~w_panel_rst & w_full & ~w_pop;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_level     = w_panel_rst ? '0 : r_count;

  // Storage needs no reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge HCLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {r_push_rs, r_push_data};
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_panel_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + LVLW'(1);
        2'b01:   r_count <= r_count - LVLW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid   = w_valid;
  assign out_word    = w_valid ? w_head[15:0] : 16'h0000;
  assign out_is_data = w_valid & w_head[16];
  assign fifo_level  = w_level;

  // --------------------------------------------------------------------------
  // Sticky overflow. A new drop takes priority over a clear in the same
  // cycle. Panel reset deliberately leaves it untouched.
  // --------------------------------------------------------------------------
  logic r_ovf;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign overflow = r_ovf;

  // --------------------------------------------------------------------------
  // Command tracking. Every decoded command updates last_cmd, including one
  // that is dropped by a full FIFO.
  // --------------------------------------------------------------------------
  logic [7:0] r_last_cmd;
  logic [7:0] w_last_cmd;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last_cmd <= 8'h00;
    end else if (w_panel_rst) begin
      r_last_cmd <= 8'h00;
    end else if (r_push_vld & ~r_push_rs) begin
      r_last_cmd <= r_push_data[7:0];
    end
  end

  assign w_last_cmd = w_panel_rst ? 8'h00 : r_last_cmd;

  // --------------------------------------------------------------------------
  // Read response. OE follows the synchronised strobes directly. The data
  // mux falls back to a holding register so the bus value stays put while
  // OE is low.
  // --------------------------------------------------------------------------
  logic        w_rd_act;
  logic [15:0] w_resp;
  logic [15:0] r_dout_hold;

  assign w_rd_act = ~r_cs_s2 & ~r_rd_s2;
  assign w_resp   = (w_last_cmd == c_CMD_ID) ? ID_CODE
                                             : {r_ovf, 7'b000_0000, 8'(w_level)};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dout_hold <= 16'h0000;
    end else if (w_rd_act) begin
      r_dout_hold <= w_resp;
    end
  end

  assign LCD_DATA_OE  = w_rd_act;
  assign LCD_DATA_OUT = w_rd_act ? w_resp : r_dout_hold;
  assign lcd_reset_active = w_panel_rst;

  // --------------------------------------------------------------------------
  // Pixel counter. A memory-write command (0x2C) restarts the count. Each
  // accepted data word written under that command advances the count,
  // which saturates at all-ones.
  // --------------------------------------------------------------------------
`ifdef LCD_8080_RX_PIXCNT_EN
  localparam logic [7:0] c_CMD_RAMWR = 8'h2C;

  logic [PIXW-1:0] r_pix;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pix <= '0;
    end else if (w_panel_rst) begin
      r_pix <= '0;
    end else if (r_push_vld & ~r_push_rs & (r_push_data[7:0] == c_CMD_RAMWR)) begin
      r_pix <= '0;
    end else if (w_push_ok & r_push_rs & (r_last_cmd == c_CMD_RAMWR) & (r_pix != '1)) begin
      r_pix <= r_pix + PIXW'(1);
    end
  end

  assign pix_count = w_panel_rst ? '0 : r_pix;
`else
  assign pix_count = {PIXW{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_8080_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_8080_rx
// Purpose  : Self-checking bench for lcd_8080_rx. A queue-based model tracks
//            the pins as seen through the synchronisers and checks every
//            output on each falling clock edge. Directed sequences pin the
//            model with literal values, and a randomized 8080 traffic phase
//            follows them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_8080_rx;

  localparam int          DEPTH   = 8;
  localparam int          LVLW    = 4;
  localparam int          PIXW    = 20;
  localparam logic [15:0] ID_CODE = 16'h9341;

  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic            LCD_CS = 1'b1, LCD_RS = 1'b0, LCD_WR = 1'b1, LCD_RD = 1'b1, LCD_RST = 1'b1;
  logic [15:0]     LCD_DATA_IN = 16'h0000;
  logic            out_ready = 1'b0, ovf_clr = 1'b0;
  logic [15:0]     LCD_DATA_OUT;
  logic            LCD_DATA_OE, out_valid, out_is_data, overflow, lcd_reset_active;
  logic [15:0]     out_word;
  logic [LVLW-1:0] fifo_level;
  logic [PIXW-1:0] pix_count;

  lcd_8080_rx #(.DEPTH(DEPTH), .LVLW(LVLW), .ID_CODE(ID_CODE), .PIXW(PIXW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD), .LCD_RST(LCD_RST),
    .LCD_DATA_IN(LCD_DATA_IN), .LCD_DATA_OUT(LCD_DATA_OUT), .LCD_DATA_OE(LCD_DATA_OE),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_data(out_is_data), .out_word(out_word),
    .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr),
    .lcd_reset_active(lcd_reset_active), .pix_count(pix_count)
  );

  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. h[0] holds the pins sampled at the latest edge and h[1]
  // the edge before, and so on. The synchronised view of a pin therefore
  // lags by two edges. A write edge enters the FIFO three edges after WR is
  // first sampled high.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic        cs, rs, wr, rd, rst;
    logic [15:0] data;
  } pins_t;

  pins_t       h [4];
  logic [16:0] mq [$];
  logic        m_ovf;
  logic [7:0]  m_last;
  int unsigned m_pix;
  logic [15:0] m_hold;
  logic [16:0] obs [$];

  function automatic pins_t idle_pins();
    pins_t p;
    p.cs = 1'b1; p.rs = 1'b0; p.wr = 1'b1; p.rd = 1'b1; p.rst = 1'b1; p.data = 16'h0000;
    return p;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin : model
    pins_t       cur;
    bit          rstlow, push, pop, acc, drop;
    logic [16:0] w;
    if (!HRESETn) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_last = 8'h00;
      m_pix  = 0;
      for (int i = 0; i < 4; i++) h[i] = idle_pins();
    end else begin
      cur.cs = LCD_CS; cur.rs = LCD_RS; cur.wr = LCD_WR; cur.rd = LCD_RD;
      cur.rst = LCD_RST; cur.data = LCD_DATA_IN;
      rstlow = !h[1].rst;
      push   = h[2].wr && !h[3].wr && !h[2].cs;
      w      = {h[2].rs, h[2].data};
      pop    = (mq.size() != 0) && !rstlow && out_ready;
      acc    = 1'b0;
      drop   = 1'b0;
      if (rstlow) begin
        mq.delete();
        m_last = 8'h00;
        m_pix  = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          if (mq.size() < DEPTH) begin
            mq.push_back(w);
            acc = 1'b1;
          end else begin
            drop = 1'b1;
          end
          if (!w[16] && w[7:0] == 8'h2C) m_pix = 0;
          else if (acc && w[16] && m_last == 8'h2C && m_pix < (2**PIXW - 1)) m_pix++;
          if (!w[16]) m_last = w[7:0];
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = cur;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge HCLK) begin : compare
    bit          ra, oe;
    int          lvl;
    logic [7:0]  lc;
    logic [15:0] resp;
    if (!HRESETn) begin
      m_hold = 16'h0000;
    end else begin
      ra   = !h[1].rst;
      lvl  = ra ? 0 : mq.size();
      chk("lcd_reset_active", lcd_reset_active, ra);
      chk("out_valid", out_valid, lvl != 0);
      chk("fifo_level", fifo_level, lvl);
      chk("overflow", overflow, m_ovf);
      if (lvl != 0) begin
        chk("out_word", out_word, mq[0][15:0]);
        chk("out_is_data", out_is_data, mq[0][16]);
      end
      oe   = !h[1].cs && !h[1].rd;
      lc   = ra ? 8'h00 : m_last;
      resp = (lc == 8'h04) ? ID_CODE : {m_ovf, 7'b0, 8'(lvl)};
      chk("LCD_DATA_OE", LCD_DATA_OE, oe);
      chk("LCD_DATA_OUT", LCD_DATA_OUT, oe ? resp : m_hold);
      if (oe) m_hold = resp;
`ifdef LCD_8080_RX_PIXCNT_EN
      chk("pix_count", pix_count, ra ? 0 : m_pix);
`else
      chk("pix_count", pix_count, 0);
`endif
      if (out_valid && out_ready) obs.push_back({out_is_data, out_word});
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  bit rnd_mode  = 1'b0;
  int ready_pct = 50;

  task automatic tick();
    @(posedge HCLK);
    #1;
    if (rnd_mode) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      ovf_clr   = ($urandom_range(0, 31) == 0);
    end
  endtask

  task automatic wr(input logic rs, input logic [15:0] d, input int lowc);
    LCD_CS = 1'b0; LCD_RS = rs; LCD_DATA_IN = d; LCD_WR = 1'b0;
    repeat (lowc) tick();
    LCD_WR = 1'b1;
    repeat (3) tick();
  endtask

  task automatic rd(input int lowc);
    LCD_CS = 1'b0; LCD_RD = 1'b0;
    repeat (lowc) tick();
    LCD_RD = 1'b1;
    tick();
  endtask

  logic [7:0] cmds [5];

  initial begin : stim
    int base;
    logic [7:0]  c8;
    logic [15:0] d16;
    cmds[0] = 8'h04; cmds[1] = 8'h2C; cmds[2] = 8'h2A; cmds[3] = 8'h00; cmds[4] = 8'h3A;

    // Reset state
    repeat (3) @(negedge HCLK);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_word", out_word, 0);
    chk("rst out_is_data", out_is_data, 0);
    chk("rst fifo_level", fifo_level, 0);
    chk("rst overflow", overflow, 0);
    chk("rst LCD_DATA_OE", LCD_DATA_OE, 0);
    chk("rst LCD_DATA_OUT", LCD_DATA_OUT, 0);
    chk("rst lcd_reset_active", lcd_reset_active, 0);
    chk("rst pix_count", pix_count, 0);
    @(posedge HCLK); #1 HRESETn = 1'b1;

    // Command 0x2A and two data words; latency of the first word
    out_ready = 1'b1;
    repeat (3) tick();
    base = obs.size();
    LCD_CS = 1'b0; LCD_RS = 1'b0; LCD_DATA_IN = 16'h002A; LCD_WR = 1'b0;
    tick(); tick();
    LCD_WR = 1'b1;
    tick(); chk("latency N", out_valid, 0);
    tick(); chk("latency N+1", out_valid, 0);
    tick(); chk("latency N+2", out_valid, 0);
    tick(); chk("latency N+3", out_valid, 1);
    chk("first word", {out_is_data, out_word}, 17'h0002A);
    wr(1'b1, 16'h0000, 2);
    wr(1'b1, 16'h00EF, 2);
    repeat (6) tick();
    chk("t1 words out", obs.size() - base, 3);
    if (obs.size() >= base + 3) begin
      chk("t1 word0", obs[base],     17'h0002A);
      chk("t1 word1", obs[base + 1], 17'h10000);
      chk("t1 word2", obs[base + 2], 17'h100EF);
    end
    chk("t1 overflow", overflow, 0);

    // Ten writes into an 8-deep FIFO with no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) wr(1'b1, 16'h0100 + 16'(i), 1);
    repeat (4) tick();
    chk("t2 level", fifo_level, 8);
    chk("t2 overflow", overflow, 1);
    chk("t2 head", {out_is_data, out_word}, 17'h10100);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; tick();
    chk("t2 ovf_clr", overflow, 0);

    // Full FIFO, pop coincides with the push
    LCD_CS = 1'b0; LCD_RS = 1'b1; LCD_DATA_IN = 16'h0BAD; LCD_WR = 1'b0;
    tick();
    LCD_WR = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("t3 level", fifo_level, 8);
    chk("t3 overflow", overflow, 0);
    chk("t3 head", {out_is_data, out_word}, 17'h10101);

    // Read-back: ID after 0x04, status after 0x00
    out_ready = 1'b1; repeat (12) tick(); out_ready = 1'b0;
    chk("t4 drained", fifo_level, 0);
    wr(1'b0, 16'h0004, 1); repeat (3) tick();
    LCD_CS = 1'b0; LCD_RD = 1'b0; repeat (3) tick();
    chk("t4 oe", LCD_DATA_OE, 1);
    chk("t4 id", LCD_DATA_OUT, 16'h9341);
    LCD_RD = 1'b1;
    tick(); chk("t4 oe +1", LCD_DATA_OE, 1);
    tick(); chk("t4 oe +2", LCD_DATA_OE, 0);
    chk("t4 hold", LCD_DATA_OUT, 16'h9341);
    wr(1'b0, 16'h0000, 1); repeat (3) tick();
    LCD_RD = 1'b0; repeat (3) tick();
    chk("t4 status", LCD_DATA_OUT, 16'h0002);
    LCD_RD = 1'b1; repeat (2) tick();
    chk("t4 oe off", LCD_DATA_OE, 0);

    // Panel reset with three words queued; writes during it are ignored
    wr(1'b0, 16'h0004, 1); repeat (3) tick();
    chk("t5 level before", fifo_level, 3);
    LCD_RST = 1'b0; repeat (2) tick();
    chk("t5 reset_active", lcd_reset_active, 1);
    chk("t5 level", fifo_level, 0);
    chk("t5 out_valid", out_valid, 0);
    wr(1'b1, 16'h1234, 1); repeat (2) tick();
    LCD_RST = 1'b1; repeat (3) tick();
    chk("t5 reset released", lcd_reset_active, 0);
    chk("t5 level after", fifo_level, 0);
    LCD_RD = 1'b0; repeat (3) tick();
    chk("t5 last_cmd cleared", LCD_DATA_OUT, 16'h0000);
    LCD_RD = 1'b1; repeat (2) tick();
    LCD_CS = 1'b1;

    // Pixel counter
    out_ready = 1'b1;
    wr(1'b0, 16'h002C, 1);
    for (int i = 0; i < 5; i++) wr(1'b1, 16'hF800, 1);
    repeat (4) tick();
`ifdef LCD_8080_RX_PIXCNT_EN
    chk("t6 pix 5", pix_count, 5);
`else
    chk("t6 pix off", pix_count, 0);
`endif
    wr(1'b0, 16'h002C, 1); repeat (4) tick();
    chk("t6 pix cleared", pix_count, 0);
    wr(1'b1, 16'h07E0, 1); wr(1'b1, 16'h001F, 1); repeat (4) tick();
    wr(1'b0, 16'h002A, 1); wr(1'b1, 16'h0010, 1); repeat (4) tick();
`ifdef LCD_8080_RX_PIXCNT_EN
    chk("t6 pix after 2A", pix_count, 2);
`else
    chk("t6 pix after 2A", pix_count, 0);
`endif

    // Randomized traffic
    rnd_mode = 1'b1;
    for (int t = 0; t < 400; t++) begin
      int k;
      if (t % 50 == 0) begin
        k = $urandom_range(0, 2);
        ready_pct = (k == 0) ? 10 : (k == 1) ? 50 : 90;
      end
      k = $urandom_range(0, 19);
      if (k < 12) begin
        if ($urandom_range(0, 3) == 0) begin
          c8  = cmds[$urandom_range(0, 4)];
          d16 = {8'($urandom_range(0, 255)), c8};
          wr(1'b0, d16, $urandom_range(1, 3));
        end else begin
          d16 = 16'($urandom);
          wr(1'b1, d16, $urandom_range(1, 3));
        end
        if ($urandom_range(0, 1) == 0) LCD_CS = 1'b1;
      end else if (k < 16) begin
        rd($urandom_range(1, 4));
        if ($urandom_range(0, 1) == 0) LCD_CS = 1'b1;
      end else if (k < 19) begin
        LCD_DATA_IN = 16'($urandom);
        LCD_RS = 1'($urandom);
        repeat ($urandom_range(1, 3)) tick();
      end else begin
        LCD_RST = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        if ($urandom_range(0, 1) == 0) wr(1'b1, 16'($urandom), 1);
        LCD_RST = 1'b1;
        tick();
      end
    end

    rnd_mode = 1'b0;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    LCD_CS = 1'b1;
    repeat (20) tick();
    chk("final drained", fifo_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_8080_rx.md
Name: lcd_8080_rx

Overview:
- Target-side (LCD-controller-side) receiver for the 8080-style parallel LCD bus that the CPU bit-bangs through the AHB LCD GPIO peripheral (CS/RS/WR/RD/RST/DATA).
- Synchronises the asynchronous bus pins into HCLK and decodes WR cycles into command/data words.
- Buffers decoded words in a FIFO with a valid/ready output, and answers RD cycles with an ID or status word.
- Used as an on-chip display front end and as the bus target in loopback tests of the bit-bang driver.

Parameters:
- DEPTH, 8, FIFO depth in words; power of two, minimum 2.
- LVLW, 4, width of fifo_level; must equal log2(DEPTH)+1.
- ID_CODE, 16'h9341, value returned on reads following command 0x04.
- PIXW, 20, width of pix_count (optional feature only).

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- LCD_CS  in  1  chip select, active low, asynchronous to HCLK
- LCD_RS  in  1  0 = command, 1 = data
- LCD_WR  in  1  write strobe, active low; word captured on rising edge
- LCD_RD  in  1  read strobe, active low
- LCD_RST  in  1  panel reset, active low
- LCD_DATA_IN  in  16  bus data from initiator
- LCD_DATA_OUT  out  16  read-back data
- LCD_DATA_OE  out  1  read-back drive enable
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_is_data  out  1  head RS bit
- out_word  out  16  head data
- fifo_level  out  LVLW  words held
- overflow  out  1  sticky, a word was dropped
- ovf_clr  in  1  single-cycle pulse, clears overflow
- lcd_reset_active  out  1  synchronised LCD_RST is low
- pix_count  out  PIXW  pixel counter (optional feature)

Behaviour:
- Async reset: all sync flops to idle, meaning CS/WR/RD/RST = 1 and RS/DATA = 0. FIFO empty, out_valid=0, out_word=0, out_is_data=0, fifo_level=0, overflow=0, LCD_DATA_OE=0, LCD_DATA_OUT=0, last_cmd=8'h00, pix_count=0.
- Sync: CS, RS, WR, RD, RST and DATA each pass through 2 flops (s1, s2). A third flop wr_d holds the previous s2 of WR.
- Write detect: s2_WR=1 and wr_d=0 and s2_CS=0 → push {s2_RS, s2_DATA}.
  - Latency: the first HCLK edge that samples WR high is edge N. The push occurs at N+2; out_valid=1 after edge N+3 when the FIFO was empty.
  - The initiator holds data/RS stable ≥3 HCLK around WR rise. The bit-bang driver meets this by construction.
- Command tracking: on a push with RS=0, last_cmd <= DATA[7:0].
- FIFO: first-word fall-through, out_word/out_is_data show the head while out_valid=1.
  - Pop when out_valid & out_ready.
  - Push while full with a simultaneous pop: accepted, level unchanged.
  - Push while full without pop: word dropped, overflow <= 1.
  - Pop while empty: ignored.
  - Pointers wrap modulo DEPTH.
- overflow: sticky. ovf_clr clears it. If ovf_clr and a new drop occur in the same cycle, the set wins.
- Read response: while s2_CS=0 and s2_RD=0, LCD_DATA_OE=1.
  - LCD_DATA_OUT = ID_CODE if last_cmd==8'h04.
  - Otherwise LCD_DATA_OUT = {overflow, 7'b0, fifo_level zero-extended to 8 bits}.
  - OE drops 2 cycles after RD or CS rises at the pin (sync delay). LCD_DATA_OUT holds its last value while OE=0.
- RD never pops the FIFO. Simultaneous WR and RD low is illegal; a WR edge is still captured.
- Panel reset: while s2_RST=0:
  - lcd_reset_active=1.
  - FIFO flushed each cycle (level 0, out_valid 0), pushes ignored.
  - last_cmd=0, pix_count=0. overflow is preserved.
- The FIFO flush also applies if RST falls mid-burst, including when a push is pending that cycle.

Optional Feature:
- Macro LCD_8080_RX_PIXCNT_EN.
- When defined:
  - A push with RS=0 and DATA[7:0]==8'h2C clears pix_count.
  - Each accepted RS=1 push (not dropped) while last_cmd==8'h2C increments pix_count, saturating at all-ones.
  - A dropped word does not count.
- When undefined: pix_count is tied to 0 and no counter logic exists.

Test Plan:
- Reset, then write cmd 0x2A and data 0x0000, 0x00EF, out_ready=1 → three words out in order: {0,0x002A}, {1,0x0000}, {1,0x00EF}. First out_valid 3 cycles after WR rise; overflow=0.
- out_ready=0, 10 data writes with DEPTH=8 → fifo_level=8, overflow=1, first 8 words retained. ovf_clr pulse → overflow=0.
- Full FIFO, out_ready=1 while a WR edge arrives → level stays 8, no overflow.
- Cmd 0x04 then RD low → LCD_DATA_OE=1, LCD_DATA_OUT=0x9341. Cmd 0x00 then RD → 0x0000|level; OE falls 2 cycles after RD high.
- 3 words queued, LCD_RST low 4 cycles → lcd_reset_active=1, level=0, out_valid=0, last_cmd=0. Writes during RST are ignored.
- With LCD_8080_RX_PIXCNT_EN: cmd 0x2C then 5 data writes → pix_count=5. Cmd 0x2C again → 0. Cmd 0x2A plus data → unchanged.
